// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Rev 1.0
`default_nettype none

package dmem_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Error reasons, held in reserve for byte/half-word access support.
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with registered read, no reset.
// Rev 1.0
`default_nettype none

module dmem_array #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata <= mem_q[idx];
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder that stalls the core until
// each word access completes. Rev 1.0
`default_nettype none

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS   = 256,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0]      DEPTH_U = DEPTH_WORDS;
   localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_LATENCY - 1);

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, err_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic             resp_valid_q, resp_err_q, resp_rd_q;

   logic             w_accept, w_req_err, w_enter_resp;
   logic             w_acc_we, w_acc_err, w_mem_we;
   logic [IDX_W-1:0] w_acc_idx;
   logic [31:0]      w_acc_wdata, w_mem_rdata;
   logic [CNT_W-1:0] w_lat_cnt;

   // Full-width word-index compare so high address bits never alias low words.
   assign w_req_err = (req_addr[1:0] != 2'b00) | ({2'b00, req_addr[31:2]} >= DEPTH_U);
   assign w_accept  = (state_q == IDLE) & req_valid;
   assign w_lat_cnt = req_we ? WR_CNT : RD_CNT;

   // A latency-1 access hits the array on its accept edge, before the latch
   // registers hold it, so the live request fields are used in IDLE.
   assign w_acc_we    = (state_q == IDLE) ? req_we            : we_q;
   assign w_acc_err   = (state_q == IDLE) ? w_req_err         : err_q;
   assign w_acc_idx   = (state_q == IDLE) ? req_addr[IDX_W+1:2] : idx_q;
   assign w_acc_wdata = (state_q == IDLE) ? req_wdata         : wdata_q;
   assign w_mem_we    = w_enter_resp & w_acc_we & ~w_acc_err;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      w_enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (w_req_err || (w_lat_cnt == '0)) begin
                  state_d      = RESP;
                  cnt_d        = '0;
                  w_enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = w_lat_cnt;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 4'd1) begin
               state_d      = RESP;
               cnt_d        = '0;
               w_enter_resp = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_accept) begin
            we_q    <= req_we;
            err_q   <= w_req_err;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
         end
         resp_valid_q <= w_enter_resp;
         resp_err_q   <= w_enter_resp & w_acc_err;
         resp_rd_q    <= w_enter_resp & ~w_acc_we & ~w_acc_err;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_mem_we),
      .idx   (w_acc_idx),
      .wdata (w_acc_wdata),
      .rdata (w_mem_rdata)
   );

   assign stall      = req_valid & ~resp_valid_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rd_q ? w_mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Rev 1.0
`default_nettype none

module tb_dmem_responder;

   localparam int DEPTH = 256;

   logic        clk;
   logic        reset;
   logic        req_valid [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        stall     [2];
   logic        resp_valid[2];
   logic [31:0] resp_rdata[2];
   logic        resp_err  [2];

   int rlat [2] = '{2, 4};
   int wlat [2] = '{1, 3};

   logic [31:0] mdl   [2][DEPTH];
   bit          known [2][DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .stall(stall[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(4), .WRITE_LATENCY(3)) u_dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .stall(stall[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_err(input logic [31:0] addr);
      longint unsigned a;
      a = addr;
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   // One complete access with the request dropped right after its response.
   task automatic access(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      int lat, k, stall_cnt;
      bit err;
      err = addr_err(addr);
      lat = err ? 1 : (we ? wlat[sel] : rlat[sel]);
      @(negedge clk);
      req_valid[sel] = 1'b1;
      req_we[sel]    = we;
      req_addr[sel]  = addr;
      req_wdata[sel] = wdata;
      #1 stall_cnt = int'(stall[sel]);
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid[sel]) k = i;
         else stall_cnt += int'(stall[sel]);
      end
      check_eq("latency", k, lat);
      check_eq("stall_cycles", stall_cnt, lat);
      check_eq("stall_in_resp", {31'b0, stall[sel]}, 32'h0);
      check_eq("resp_err", {31'b0, resp_err[sel]}, {31'b0, err});
      if (err || we) check_eq("rdata_zero", resp_rdata[sel], 32'h0);
      else if (known[sel][addr / 4]) check_eq("rdata", resp_rdata[sel], mdl[sel][addr / 4]);
      if (we && !err) begin
         mdl[sel][addr / 4]   = wdata;
         known[sel][addr / 4] = 1'b1;
      end
      @(negedge clk);
      req_valid[sel] = 1'b0;
      @(posedge clk);
      #1 check_eq("pulse_width", {31'b0, resp_valid[sel]}, 32'h0);
   endtask

   // Request held high: responses every LAT+1 cycles, four accesses observed.
   task automatic held(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
      int lat, last, pulses;
      lat  = we ? wlat[sel] : rlat[sel];
      last = lat + 3 * (lat + 1);
      pulses = 0;
      @(negedge clk);
      req_valid[sel] = 1'b1;
      req_we[sel]    = we;
      req_addr[sel]  = addr;
      req_wdata[sel] = wdata;
      for (int i = 1; i <= last; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid[sel]) begin
            check_eq("b2b_pulse_pos", i, lat + pulses * (lat + 1));
            pulses++;
            if (!we) check_eq("b2b_rdata", resp_rdata[sel], mdl[sel][addr / 4]);
         end
      end
      check_eq("b2b_pulses", pulses, 4);
      if (we) begin
         mdl[sel][addr / 4]   = wdata;
         known[sel][addr / 4] = 1'b1;
      end
      @(negedge clk);
      req_valid[sel] = 1'b0;
      @(posedge clk);
   endtask

   // Reset pulsed while instance sel is waiting; the access must vanish.
   task automatic reset_in_wait(input int sel, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      int seen;
      @(negedge clk);
      req_valid[sel] = 1'b1;
      req_we[sel]    = we;
      req_addr[sel]  = addr;
      req_wdata[sel] = wdata;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      req_valid[sel] = 1'b0;
      #1;
      check_eq("rst_resp_valid", {31'b0, resp_valid[sel]}, 32'h0);
      check_eq("rst_resp_err", {31'b0, resp_err[sel]}, 32'h0);
      check_eq("rst_rdata", resp_rdata[sel], 32'h0);
      check_eq("rst_stall", {31'b0, stall[sel]}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 seen += int'(resp_valid[sel]);
      end
      check_eq("rst_no_resp", seen, 0);
   endtask

   initial begin
      logic [31:0] a, d;
      int sel, r;
      bit we;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0;
         req_we[s]    = 1'b0;
         req_addr[s]  = '0;
         req_wdata[s] = '0;
         for (int w = 0; w < DEPTH; w++) known[s][w] = 1'b0;
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         for (int s = 0; s < 2; s++) begin
            check_eq("idle_resp_valid", {31'b0, resp_valid[s]}, 32'h0);
            check_eq("idle_resp_err", {31'b0, resp_err[s]}, 32'h0);
            check_eq("idle_rdata", resp_rdata[s], 32'h0);
            check_eq("idle_stall", {31'b0, stall[s]}, 32'h0);
         end
      end

      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 16; w++) access(s, 1'b1, w * 4, $urandom);
         access(s, 1'b1, 32'h3FC, $urandom);
      end

      access(0, 1'b1, 32'h10, 32'hDEADBEEF);
      access(0, 1'b0, 32'h10, 32'h0);
      access(0, 1'b0, 32'h13, 32'h0);
      access(0, 1'b1, 32'h400, 32'h12345678);
      access(0, 1'b0, 32'h0, 32'h0);
      access(0, 1'b0, 32'h3FC, 32'h0);
      access(0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5A5A5);
      access(0, 1'b0, 32'h0, 32'h0);

      reset_in_wait(1, 1'b0, 32'h8, 32'h0);
      access(1, 1'b0, 32'h8, 32'h0);
      reset_in_wait(1, 1'b1, 32'hC, 32'hCAFEF00D);
      access(1, 1'b0, 32'hC, 32'h0);

      held(0, 1'b0, 32'h10, 32'h0);
      held(1, 1'b1, 32'h20, 32'h600DF00D);
      access(1, 1'b0, 32'h20, 32'h0);

      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom % 2);
         r   = int'($urandom % 10);
         we  = bit'($urandom % 2);
         d   = $urandom;
         if (r == 0)      a = ($urandom % 16) * 4 + 1 + ($urandom % 3);
         else if (r == 1) a = 32'h400 + ($urandom % 64) * 4;
         else if (r == 2) a = 32'hFFFF_FFFC;
         else if (r == 3) a = 32'h3FC;
         else             a = ($urandom % 16) * 4;
         access(sel, we, a, d);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the processor's data-memory port. It accepts one word read or write request at a time, serves it from an internal word array after a configurable number of wait cycles, and asserts `stall` back to the core. `stall` drives the core's `pause` input, so the single-cycle datapath holds its PC and control signals until `resp_valid` completes the access. It sits between the core's load/store path (ALU result as address, rt register as write data) and the memory array, replacing the zero-latency data memory when wait states are modelled.

## Interface

Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; valid word index is 0..DEPTH_WORDS-1.
- `READ_LATENCY`, 2: cycles from accept edge to `resp_valid` for reads; legal range 1..15.
- `WRITE_LATENCY`, 1: the same for writes; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present. The core holds it and all request fields stable until `resp_valid`.
- `req_we` input 1: 1 means write, 0 means read (driven from MemWrite; MemRead alone means read).
- `req_addr` input 32: byte address. It must be word aligned.
- `req_wdata` input 32: write data.
- `stall` output 1: combinational, `req_valid & ~resp_valid`. Connect it to the core's `pause`.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: read data. It is valid only while `resp_valid=1` and the response is a read with no error.
- `resp_err` output 1: qualifies `resp_valid`. It flags a misaligned or out-of-range access.

## Operation

- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE with `req_valid=1`: latch `req_we`, `req_addr` and `req_wdata` (the accept edge). Compute `err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS)`.
- After accepting:
  - If `err=1`, go to RESP immediately.
  - Otherwise load `cnt = LAT-1`, where LAT is the read or write latency as selected by `req_we`.
  - If `cnt==0`, go to RESP. Otherwise go to WAIT.
- WAIT: decrement `cnt`. On the edge where `cnt` is 1, go to RESP.
- Entering RESP (non-error):
  - A write updates `mem[addr[31:2]]` at this edge.
  - A read registers `mem[addr[31:2]]` into `resp_rdata` at this edge.
- RESP: `resp_valid=1` for exactly one cycle, then go to IDLE. `req_valid` is not sampled in RESP.
- Error responses: no array write, `resp_rdata=0`, `resp_err=1`.
- Read-after-write to the same word returns the new data, because the write has completed before the read is accepted.
- The memory array is not cleared by reset.

## Timing

- Reset values: `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `cnt=0`, state IDLE. `stall` follows `req_valid`.
- Latency: `resp_valid` is high exactly LAT cycles after the accept edge. For errors LAT is 1.
- Throughput: one access per LAT+1 cycles. A request held high across RESP is re-accepted in the IDLE cycle that follows. The core must change or drop the request after `resp_valid`.
- `req_valid` dropping while in WAIT is a protocol violation. The access still completes, and a write is still performed.
- Reset asserted mid-access:
  - State returns to IDLE immediately.
  - A pending write is discarded if its RESP-entry edge has not yet occurred.
  - No `resp_valid` is produced.
- Width rules: `cnt` is 4 bits. Word index is `addr[31:2]` compared at full width, so no truncation aliasing can occur.

## Structure

- Shared package `dmem_pkg`:
  - State enum `dmem_state_t` (IDLE, WAIT, RESP).
  - `CNT_W=4`.
  - Error-reason constants, which are reserved for future byte/half support.
- Sub-module `dmem_array`: synchronous single-port word RAM. Its ports are `clk`, `we`, `idx`, `wdata` and `rdata`, with registered read. It has no reset.
- The FSM, latch registers and counter live in `dmem_responder`.

## Test plan

- Reset release, no request: all outputs 0, `stall=0`, for 5 cycles.
- Write of 0xDEADBEEF to 0x10 (WRITE_LATENCY=1), then read of 0x10 (READ_LATENCY=2):
  - Write: `resp_valid` 1 cycle after accept, `stall` high for 1 cycle.
  - Read: `resp_valid` 2 cycles after accept, `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- Misaligned read at 0x13: `resp_valid` 1 cycle after accept, `resp_err=1`, `resp_rdata=0`, no array change.
- Out-of-range address 0x400 with DEPTH_WORDS=256:
  - Write: `resp_err=1`.
  - A subsequent read of 0x0 returns its prior value, showing no wrap into word 0.
- Read with READ_LATENCY=4 and `reset` pulsed low during WAIT: no `resp_valid`, state IDLE, outputs 0.
- Write with WRITE_LATENCY=3 and `reset` pulsed low during WAIT: no `resp_valid`, and a following read of the same word returns its old value.
- Back-to-back requests held high: exactly one IDLE cycle between RESP pulses, and each access completes once.
